// File: rtl/pulse_monitor.sv
// Pulse-interval monitor for a single-cycle strobe stream.
// Measures the spacing between strobes, qualifies the stream as locked after a
// run of in-window intervals, flags early/late strobes, and flywheels through
// isolated missing strobes while locked. All outputs are registered.
module pulse_monitor #(
  parameter int unsigned ExpectedPeriod = 16,
  parameter int unsigned Tolerance      = 1,
  parameter int unsigned LockCount      = 4,
  parameter int unsigned MaxMisses      = 2,
  localparam int unsigned W             = $clog2(ExpectedPeriod + Tolerance + 2)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pulse_in,
  output logic         locked,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic         out_of_window,
  output logic         missed
);

  // Counter widths sized so the terminal values (LockCount, MaxMisses) fit.
  localparam int unsigned GoodW = $clog2(LockCount + 1);
  localparam int unsigned MissW = $clog2(MaxMisses + 1);

  // Window bounds and flywheel restart value, pre-sized to the count width.
  localparam logic [W-1:0] WinLo     = W'(ExpectedPeriod - Tolerance);
  localparam logic [W-1:0] WinHi     = W'(ExpectedPeriod + Tolerance);
  localparam logic [W-1:0] FlyCount  = W'(Tolerance + 1);
  localparam logic [W-1:0] CountOne  = W'(1);

  // Last value of the run counters before they hit their terminal event.
  localparam logic [GoodW-1:0] GoodLast = GoodW'(LockCount - 1);
  localparam logic [MissW-1:0] MissLast = MissW'(MaxMisses - 1);
  localparam logic [GoodW-1:0] GoodOne  = GoodW'(1);
  localparam logic [MissW-1:0] MissOne  = MissW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StTrack,
    StLocked
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     count_q, count_d;
  logic [GoodW-1:0] good_q, good_d;
  logic [MissW-1:0] misses_q, misses_d;
  logic             locked_q, locked_d;
  logic [W-1:0]     period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             oow_q, oow_d;
  logic             missed_q, missed_d;

  logic in_window;
  logic window_close;

  // Interval classification for a pulse arriving this cycle.
  always_comb begin
    in_window    = (count_q >= WinLo) && (count_q <= WinHi);
    window_close = (count_q == WinHi);
  end

  // Next-state and output decode. Strobes default low and pulse for a single
  // cycle; a pulse on the window-close cycle takes precedence over a miss.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    good_d         = good_q;
    misses_d       = misses_q;
    locked_d       = locked_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    oow_d          = 1'b0;
    missed_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // First pulse only establishes the reference; no interval yet.
        if (pulse_in) begin
          state_d = StTrack;
          count_d = CountOne;
          good_d  = '0;
        end
      end

      StTrack: begin
        if (pulse_in) begin
          period_d       = count_q;
          period_valid_d = 1'b1;
          count_d        = CountOne;
          if (in_window) begin
            if (good_q == GoodLast) begin
              state_d  = StLocked;
              locked_d = 1'b1;
              misses_d = '0;
              good_d   = '0;
            end else begin
              good_d = good_q + GoodOne;
            end
          end else begin
            oow_d  = 1'b1;
            good_d = '0;
          end
        end else if (window_close) begin
          // No flywheel before lock: lose the reference entirely.
          missed_d = 1'b1;
          state_d  = StIdle;
          good_d   = '0;
          count_d  = '0;
        end else begin
          count_d = count_q + CountOne;
        end
      end

      StLocked: begin
        if (pulse_in) begin
          period_d       = count_q;
          period_valid_d = 1'b1;
          count_d        = CountOne;
          if (in_window) begin
            misses_d = '0;
          end else begin
            oow_d    = 1'b1;
            locked_d = 1'b0;
            state_d  = StTrack;
            good_d   = '0;
          end
        end else if (window_close) begin
          missed_d = 1'b1;
          if (misses_q == MissLast) begin
            state_d  = StIdle;
            locked_d = 1'b0;
            count_d  = '0;
            misses_d = '0;
          end else begin
            // Virtual reference at ExpectedPeriod after the previous one; we
            // are Tolerance+1 cycles past it on the next cycle.
            misses_d = misses_q + MissOne;
            count_d  = FlyCount;
          end
        end else begin
          count_d = count_q + CountOne;
        end
      end

      default: begin
        state_d  = StIdle;
        count_d  = '0;
        good_d   = '0;
        misses_d = '0;
        locked_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      count_q        <= '0;
      good_q         <= '0;
      misses_q       <= '0;
      locked_q       <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      oow_q          <= 1'b0;
      missed_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      good_q         <= good_d;
      misses_q       <= misses_d;
      locked_q       <= locked_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      oow_q          <= oow_d;
      missed_q       <= missed_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    locked        = locked_q;
    period        = period_q;
    period_valid  = period_valid_q;
    out_of_window = oow_q;
    missed        = missed_q;
  end

endmodule
